// File: rtl/injector_ctrl.sv
// ----------------------------------------------------------------------------
// injector_ctrl
// Sequencer for a single bias generator / signal injector. It accepts trim and
// stimulus settings over a valid/ready port. Trims are changed only while the
// injector is disabled, with a settle interval on each side of the change.
// While running, it produces the injected pattern: constant, square wave or
// PRBS7. Every output is a register.
//
// Ports
//   clk          block clock
//   rst_n        asynchronous reset, active-low
//   run          level request for an active injector
//   cfg_valid    configuration offered
//   cfg_ready    configuration accepted when cfg_valid & cfg_ready at clk edge
//   cfg_trim_p   pull-up trim   (0 = weakest)
//   cfg_trim_n   pull-down trim (0 = weakest)
//   cfg_mode     0 = const 0, 1 = const 1, 2 = square, 3 = PRBS7
//   cfg_div      tick period = cfg_div + 1 cycles
//   inj_enable   injector enable
//   inj_trim_p   injector pull-up trim
//   inj_trim_n   injector pull-down trim
//   inj_signal   injected signal
//   busy         high while quiescing or settling
// ----------------------------------------------------------------------------
module injector_ctrl #(
    parameter int DIV_W      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_trim_p,
    input  logic [3:0]       cfg_trim_n,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             inj_enable,
    output logic [3:0]       inj_trim_p,
    output logic [3:0]       inj_trim_n,
    output logic             inj_signal,
    output logic             busy
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [6:0] LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUIESCE,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       pend_trim_p_reg;
    logic [3:0]       pend_trim_n_reg;
    logic [1:0]       pend_mode_reg;
    logic [DIV_W-1:0] pend_div_reg;
    logic [1:0]       mode_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] tick_cnt_reg;
    logic [6:0]       lfsr_reg;

    logic       accept;
    logic       tick;
    logic [6:0] lfsr_next;

    assign accept    = cfg_valid & cfg_ready;
    assign tick      = (tick_cnt_reg == div_reg);
    assign lfsr_next = {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[5]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            pend_trim_p_reg <= '0;
            pend_trim_n_reg <= '0;
            pend_mode_reg   <= '0;
            pend_div_reg    <= '0;
            mode_reg        <= '0;
            div_reg         <= '0;
            tick_cnt_reg    <= '0;
            lfsr_reg        <= LFSR_SEED;
            cfg_ready       <= 1'b1;
            inj_enable      <= 1'b0;
            inj_trim_p      <= '0;
            inj_trim_n      <= '0;
            inj_signal      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    inj_enable   <= 1'b0;
                    inj_signal   <= 1'b0;
                    tick_cnt_reg <= '0;
                    lfsr_reg     <= LFSR_SEED;
                    if (accept) begin
                        // Injector is off, so the trims can be applied directly.
                        inj_trim_p <= cfg_trim_p;
                        inj_trim_n <= cfg_trim_n;
                        mode_reg   <= cfg_mode;
                        div_reg    <= cfg_div;
                        cfg_ready  <= 1'b0;
                    end else if (run) begin
                        state_reg <= S_SETTLE;
                        cnt_reg   <= SETTLE_LOAD;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (!run) begin
                        state_reg <= S_IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (cnt_reg == '0) begin
                        state_reg    <= S_RUN;
                        inj_enable   <= 1'b1;
                        cfg_ready    <= 1'b1;
                        busy         <= 1'b0;
                        tick_cnt_reg <= '0;
                        // First RUN cycle already shows the pattern's initial value.
                        case (mode_reg)
                            2'd2:    inj_signal <= 1'b0;
                            2'd3:    inj_signal <= lfsr_reg[6];
                            default: inj_signal <= mode_reg[0];
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                S_RUN: begin
                    if (accept || !run) begin
                        // A capture wins over a simultaneous run drop.
                        inj_enable   <= 1'b0;
                        inj_signal   <= 1'b0;
                        tick_cnt_reg <= '0;
                        lfsr_reg     <= LFSR_SEED;
                        if (accept) begin
                            pend_trim_p_reg <= cfg_trim_p;
                            pend_trim_n_reg <= cfg_trim_n;
                            pend_mode_reg   <= cfg_mode;
                            pend_div_reg    <= cfg_div;
                            state_reg       <= S_QUIESCE;
                            cnt_reg         <= SETTLE_LOAD;
                            cfg_ready       <= 1'b0;
                            busy            <= 1'b1;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else if (tick) begin
                        tick_cnt_reg <= '0;
                        case (mode_reg)
                            2'd2: inj_signal <= ~inj_signal;
                            2'd3: begin
                                lfsr_reg   <= lfsr_next;
                                inj_signal <= lfsr_next[6];
                            end
                            default: inj_signal <= mode_reg[0];
                        endcase
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end
                end

                S_QUIESCE: begin
                    // run is only looked at on the exit edge; the pending
                    // configuration is always applied.
                    if (cnt_reg == '0) begin
                        inj_trim_p <= pend_trim_p_reg;
                        inj_trim_n <= pend_trim_n_reg;
                        mode_reg   <= pend_mode_reg;
                        div_reg    <= pend_div_reg;
                        if (run) begin
                            state_reg <= S_SETTLE;
                            cnt_reg   <= SETTLE_LOAD;
                        end else begin
                            state_reg <= S_IDLE;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg  <= S_IDLE;
                    inj_enable <= 1'b0;
                    cfg_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_injector_ctrl.sv
// ----------------------------------------------------------------------------
// tb_injector_ctrl
// Directed bench for injector_ctrl (DIV_W = 8, SETTLE_CYC = 16). Inputs are
// driven and outputs sampled 1 ns after each rising edge. A negedge monitor
// checks that the trims stay constant while the injector is enabled.
// ----------------------------------------------------------------------------
module tb_injector_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_trim_p;
    logic [3:0] cfg_trim_n;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_div;
    logic       inj_enable;
    logic [3:0] inj_trim_p;
    logic [3:0] inj_trim_n;
    logic       inj_signal;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    injector_ctrl #(.DIV_W(8), .SETTLE_CYC(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_trim_p (cfg_trim_p),
        .cfg_trim_n (cfg_trim_n),
        .cfg_mode   (cfg_mode),
        .cfg_div    (cfg_div),
        .inj_enable (inj_enable),
        .inj_trim_p (inj_trim_p),
        .inj_trim_n (inj_trim_n),
        .inj_signal (inj_signal),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] tp, input logic [3:0] tn,
                         input logic [1:0] md, input logic [7:0] dv);
        cfg_valid  = 1'b1;
        cfg_trim_p = tp;
        cfg_trim_n = tn;
        cfg_mode   = md;
        cfg_div    = dv;
    endtask

    // Step until inj_enable rises (bounded), then check the edge count.
    task automatic wait_enable(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (!inj_enable && n < 60) begin
            step();
            n++;
        end
        check({tag, "_enable"}, inj_enable, 1);
        check({tag, "_latency"}, n, exp_edges);
    endtask

    // Trims must never move while enable stays high.
    logic       prev_en = 1'b0;
    logic [7:0] prev_trims = '0;
    always @(negedge clk) begin
        if (rst_n && prev_en && inj_enable)
            check("trim_hold", {inj_trim_p, inj_trim_n}, prev_trims);
        prev_en    = inj_enable;
        prev_trims = {inj_trim_p, inj_trim_n};
    end

    logic        prbs_bits [0:134];
    logic [7:0]  prbs_head;
    logic [15:0] sq_pat;
    int          ones;

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_trim_p = '0;
        cfg_trim_n = '0;
        cfg_mode   = '0;
        cfg_div    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cfg_ready, 1);
        check("rst_enable", inj_enable, 0);
        check("rst_trims", {inj_trim_p, inj_trim_n}, 8'h00);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // IDLE configuration, then run: enable 17 edges after run.
        offer(4'hA, 4'h3, 2'd1, 8'd0);
        step();
        check("idle_trim_p", inj_trim_p, 4'hA);
        check("idle_trim_n", inj_trim_n, 4'h3);
        check("idle_ready_low", cfg_ready, 0);
        cfg_valid = 1'b0;
        run = 1'b1;
        repeat (16) step();
        check("settle_enable_low", inj_enable, 0);
        check("settle_busy", busy, 1);
        step();
        check("run_enable", inj_enable, 1);
        check("run_signal_m1", inj_signal, 1);
        check("run_busy", busy, 0);
        check("run_ready", cfg_ready, 1);
        repeat (3) step();
        check("run_signal_m1_hold", inj_signal, 1);

        // Reconfigure in RUN: quiesce 16, trims change, settle 16, re-enable.
        offer(4'h5, 4'h3, 2'd2, 8'd3);
        step();
        cfg_valid = 1'b0;
        check("q_enable_low", inj_enable, 0);
        check("q_ready_low", cfg_ready, 0);
        check("q_busy", busy, 1);
        repeat (15) step();
        check("q_trim_old", inj_trim_p, 4'hA);
        step();
        check("q_trim_new", inj_trim_p, 4'h5);
        check("q_exit_enable_low", inj_enable, 0);
        repeat (15) step();
        check("s2_enable_low", inj_enable, 0);
        step();
        check("s2_enable", inj_enable, 1);

        // Square wave, div = 3: 4 cycles low, 4 high.
        sq_pat = 16'b1111_0000_1111_0000;
        check("sq_0", inj_signal, sq_pat[0]);
        for (int k = 1; k < 16; k++) begin
            step();
            check($sformatf("sq_%0d", k), inj_signal, sq_pat[k]);
        end

        // PRBS7, div = 0.
        offer(4'h5, 4'h3, 2'd3, 8'd0);
        step();
        cfg_valid = 1'b0;
        check("p_enable_low", inj_enable, 0);
        wait_enable("prbs", 32);
        prbs_bits[0] = inj_signal;
        for (int k = 1; k < 135; k++) begin
            step();
            prbs_bits[k] = inj_signal;
        end
        prbs_head = 8'b0111_1111;   // bit k = k-th output: 1,1,1,1,1,1,1,0
        for (int k = 0; k < 8; k++) begin
            check($sformatf("prbs_head_%0d", k), prbs_bits[k], prbs_head[k]);
            check($sformatf("prbs_wrap_%0d", k), prbs_bits[k + 127], prbs_head[k]);
        end
        ones = 0;
        for (int k = 0; k < 127; k++) ones += int'(prbs_bits[k]);
        check("prbs_ones", ones, 64);

        // run drops in RUN, then during SETTLE.
        run = 1'b0;
        step();
        check("drop_run_enable", inj_enable, 0);
        check("drop_run_signal", inj_signal, 0);
        run = 1'b1;
        step();
        check("s3_busy", busy, 1);
        repeat (2) step();
        run = 1'b0;
        step();
        check("drop_settle_busy", busy, 0);
        check("drop_settle_ready", cfg_ready, 1);
        repeat (20) step();
        check("drop_settle_idle", inj_enable, 0);

        // run drops during QUIESCE while another offer is held.
        run = 1'b1;
        wait_enable("r4", 17);
        offer(4'h7, 4'hC, 2'd0, 8'd0);
        step();
        offer(4'h2, 4'h9, 2'd1, 8'd0);
        run = 1'b0;
        repeat (5) step();
        check("hold_ready_low", cfg_ready, 0);
        check("hold_trim_p", inj_trim_p, 4'h5);
        repeat (5) step();
        cfg_valid = 1'b0;
        repeat (6) step();
        check("qexit_trim_p", inj_trim_p, 4'h7);
        check("qexit_trim_n", inj_trim_n, 4'hC);
        check("qexit_enable", inj_enable, 0);
        check("qexit_busy", busy, 0);
        check("qexit_ready", cfg_ready, 1);
        step();
        check("qexit_idle", inj_enable, 0);

        // Asynchronous reset while running.
        run = 1'b1;
        wait_enable("r5", 17);
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("arst_enable", inj_enable, 0);
        check("arst_trims", {inj_trim_p, inj_trim_n}, 8'h00);
        check("arst_signal", inj_signal, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("post_rst_idle", inj_enable, 0);
        check("post_rst_ready", cfg_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
